// File: rtl/branch_pkg.sv
// Shared opcode, register and FSM definitions for the ID-stage branch resolver.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLTZ = 3'b010;
  localparam logic [2:0] BR_BGEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLEZ = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    StIdle,
    StWait
  } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator on signed, already-forwarded operands.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              taken
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = a[DATA_W-1];
  assign a_zero = (a == '0);

  // Decode the branch condition; reserved encodings never take.
  always_comb begin
    taken = 1'b0;
    case (op)
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BLTZ: taken = a_neg;
      BR_BGEZ: taken = !a_neg;
      BR_BGTZ: taken = !a_neg && !a_zero;
      BR_BLEZ: taken = a_neg || a_zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: hazard stall FSM, MEM/WB forwarding, registered redirect
// and saturating performance counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid_id,
  input  logic [2:0]        br_op_id,
  input  logic              flush_id,
  input  logic [4:0]        rs_addr_id,
  input  logic [4:0]        rt_addr_id,
  input  logic [DATA_W-1:0] rs_data_id,
  input  logic [DATA_W-1:0] rt_data_id,
  input  logic [ADDR_W-1:0] pc_plus4_id,
  input  logic [15:0]       imm_id,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_wr_addr,
  input  logic              mem_wr_en,
  input  logic              mem_is_load,
  input  logic [4:0]        mem_wr_addr,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              wb_wr_en,
  input  logic [4:0]        wb_wr_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_id,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  br_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        k_rs, k_rt, k;
  logic              uses_rt;
  logic              resolve;
  logic              taken;
  logic [DATA_W-1:0] op_a, op_b;
  logic [ADDR_W-1:0] offset, target;
  logic              redirect_valid_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic [CNT_W-1:0]  br_count_q, taken_count_q, stall_count_q;

  // Stall cycles still needed before a source value becomes forwardable.
  function automatic logic [1:0] hazard_need(input logic [4:0] addr);
    logic [1:0] need;
    need = 2'd0;
    if (addr != REG_ZERO) begin
      if (ex_wr_en && (addr == ex_wr_addr)) begin
        need = ex_is_load ? 2'd2 : 2'd1;
      end else if (mem_wr_en && mem_is_load && (addr == mem_wr_addr)) begin
        need = 2'd1;
      end
    end
    return need;
  endfunction

  // Forwarded operand: MEM ALU result, then WB data, then register file.
  function automatic logic [DATA_W-1:0] fwd_value(input logic [4:0]        addr,
                                                  input logic [DATA_W-1:0] rf_data);
    logic [DATA_W-1:0] val;
    if (addr == REG_ZERO) begin
      val = '0;
    end else if (mem_wr_en && !mem_is_load && (addr == mem_wr_addr)) begin
      val = mem_alu_result;
    end else if (wb_wr_en && (addr == wb_wr_addr)) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // Worst-case hazard over the sources this op actually reads.
  always_comb begin
    uses_rt = (br_op_id == BR_BEQ) || (br_op_id == BR_BNE);
    k_rs    = hazard_need(rs_addr_id);
    k_rt    = uses_rt ? hazard_need(rt_addr_id) : 2'd0;
    k       = (k_rs > k_rt) ? k_rs : k_rt;
    op_a    = fwd_value(rs_addr_id, rs_data_id);
    op_b    = fwd_value(rt_addr_id, rt_data_id);
    offset  = {{(ADDR_W-16){imm_id[15]}}, imm_id} << 2;
    target  = pc_plus4_id + offset;
  end

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond (
    .op    (br_op_id),
    .a     (op_a),
    .b     (op_b),
    .taken (taken)
  );

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: flush or a vanished branch aborts any pending wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_id) begin
      state_d = StIdle;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (br_valid_id && (k != 2'd0)) begin
            state_d = StWait;
            cnt_d   = k - 2'd1;
          end
        end
        StWait: begin
          if (!br_valid_id || (cnt_q == 2'd0)) begin
            state_d = StIdle;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Outputs of the FSM: stall request and resolve strobe.
  always_comb begin
    stall_id = 1'b0;
    resolve  = 1'b0;
    if (!flush_id && br_valid_id) begin
      case (state_q)
        StIdle: begin
          stall_id = (k != 2'd0);
          resolve  = (k == 2'd0);
        end
        StWait: begin
          stall_id = (cnt_q != 2'd0);
          resolve  = (cnt_q == 2'd0);
        end
        default: ;
      endcase
    end
  end

  // Registered redirect and saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_count_q       <= '0;
      taken_count_q    <= '0;
      stall_count_q    <= '0;
    end else begin
      redirect_valid_q <= resolve && taken;
      redirect_pc_q    <= (resolve && taken) ? target : '0;
      if (resolve && (br_count_q != CntMax)) br_count_q <= br_count_q + 1'b1;
      if (resolve && taken && (taken_count_q != CntMax)) begin
        taken_count_q <= taken_count_q + 1'b1;
      end
      if (stall_id && (stall_count_q != CntMax)) stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush_if       = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign br_count       = br_count_q;
  assign taken_count    = taken_count_q;
  assign stall_count    = stall_count_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
ID-stage branch resolver and the parametrised successor of the level-triggered equality checker. It supports six conditional branch ops, forwards operands from MEM and WB, and stalls via a small FSM when a producer is still in EX or is a load.
It registers the redirect decision (taken, target PC, IF flush) and keeps saturating performance counters.
It sits between the register-file read and the IF PC mux.

Parameters:
DATA_W, 32, operand width
ADDR_W, 32, PC width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
br_valid_id  in  1  branch instruction present in ID
br_op_id  in  3  000 BEQ, 001 BNE, 010 BLTZ, 011 BGEZ, 100 BGTZ, 101 BLEZ, 11x reserved
flush_id  in  1  kill the instruction in ID (exception/older redirect)
rs_addr_id, rt_addr_id  in  5  source register numbers
rs_data_id, rt_data_id  in  DATA_W  register-file read data
pc_plus4_id  in  ADDR_W  PC+4 of the branch
imm_id  in  16  branch offset in words
ex_wr_en, ex_is_load  in  1  EX-stage producer info
ex_wr_addr  in  5  EX destination register
mem_wr_en, mem_is_load  in  1  MEM-stage producer info
mem_wr_addr  in  5  MEM destination register
mem_alu_result  in  DATA_W  MEM forwarding value
wb_wr_en  in  1  WB write enable
wb_wr_addr  in  5  WB destination register
wb_data  in  DATA_W  WB forwarding value
stall_id  out  1  hold IF/ID this cycle (combinational)
redirect_valid  out  1  registered one-cycle pulse: branch taken
redirect_pc  out  ADDR_W  registered target PC
flush_if  out  1  registered one-cycle pulse, equals redirect_valid
br_count, taken_count, stall_count  out  CNT_W each  saturating counters

Behaviour:
- Reset (async, rst_n=0): state IDLE, wait counter 0, redirect_valid/flush_if 0, redirect_pc 0, all counters 0.
- Sources used: rs for all ops; rt only for BEQ/BNE. Register 0 never causes a hazard and always reads as 0.
- Hazard need k per used source:
  - 2 if ex_wr_en and addr matches ex_wr_addr and ex_is_load;
  - 1 if it matches EX and the EX producer is not a load;
  - else 1 if mem_wr_en, mem_is_load and addr matches mem_wr_addr;
  - else 0.
  - k = max over the used sources.
- FSM states: IDLE and WAIT; 2-bit counter cnt.
  - IDLE, br_valid_id=1, flush_id=0, k>0: stall_id=1, go to WAIT, cnt<=k-1.
  - IDLE, k=0: resolve this cycle.
  - WAIT, cnt!=0: stall_id=1, cnt<=cnt-1.
  - WAIT, cnt=0: stall_id=0, resolve, go to IDLE.
  - A k=2 hazard therefore stalls exactly 2 cycles; a k=1 hazard stalls 1 cycle.
- Abort: flush_id=1, or br_valid_id=0 while in WAIT, forces IDLE. No resolve, no redirect, stall_id=0. flush_id has priority over everything except reset.
- Forwarding at resolve, per source, in priority order:
  - mem_alu_result if mem_wr_en, address match and !mem_is_load;
  - else wb_data if wb_wr_en and address match;
  - else register-file data.
- Conditions on signed DATA_W values:
  - BEQ: a==b. BNE: a!=b.
  - BLTZ: a<0. BGEZ: a>=0. BGTZ: a>0. BLEZ: a<=0.
  - Reserved ops resolve not-taken.
- Target: pc_plus4_id + (sign_extend(imm_id) << 2), truncated to ADDR_W (modulo wrap).
- Resolve in cycle N: at the edge ending N, redirect_valid/flush_if <= taken and redirect_pc <= target (or 0 if not taken). Both pulses last one cycle and drop in N+2 unless another branch resolves.
- Counters (saturate at 2^CNT_W-1, never wrap):
  - br_count +1 per resolve;
  - taken_count +1 per taken resolve;
  - stall_count +1 per cycle with stall_id=1.
- Reset mid-WAIT: immediate return to IDLE, outputs 0; the stalled branch is discarded.

Decomposition:
- Package branch_pkg: BR_* opcode localparams, the FSM state encoding, REG_ZERO.
- Sub-module branch_cond_eval: combinational; takes op and forwarded operands, produces taken. It is reused by the verification reference model.

Test Plan:
- No hazard, taken BEQ: rs=rt=5, pc_plus4=0x100, imm=0x0004 -> stall_id 0; next cycle redirect_valid=1, flush_if=1, redirect_pc=0x110; br_count=1, taken_count=1.
- Load-use BNE: ex_is_load writes rs=r3, rt=0x7; after 2 stall cycles wb_data=0x8 for r3 -> stall_id high for exactly 2 cycles; redirect to target; stall_count=2.
- ALU producer in EX for rt of BEQ: 1 stall; at resolve mem_alu_result=0x22 equals rs=0x22 while the regfile rt is stale 0 -> taken. Repeat with a WB match on the same register -> MEM value wins.
- Signed ops: BLTZ rs=0xFFFF_FFFF -> taken; BGTZ rs=0 -> not taken; BLEZ rs=0 -> taken; op=110 -> not taken, br_count still increments.
- Wrap: pc_plus4=0x0000_0004, imm=0xFFFE -> redirect_pc=0xFFFF_FFFC. Also, with CNT_W=2, five taken branches -> taken_count stays 3.
- Abort/reset: flush_id during WAIT -> IDLE, no pulse. rst_n low mid-WAIT -> all outputs 0 immediately, FSM back to IDLE.
